// File: rtl/pipe_arbiter_pkg.sv
// pipe_arbiter_pkg: shared types and default widths for the pipe arbiter slice.
//   arb_state_e      - transfer FSM states
//   DEF_DATA_WIDTH   - default byte width of the data paths
//   DEF_CNT_WIDTH    - default width of the completed-transfer counter
package pipe_arbiter_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    PUSH    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/pipe_arbiter_if.sv
// pipe_arbiter_if: handshake bundle between the arbiter, its two pop-style
// sources and its push-style sink.
//   srcN_pop_front / srcN_data_out / srcN_empty - source N FIFO port
//   sink_push_back / sink_data_in / sink_full    - sink FIFO port
//   modport master : arbiter side
//   modport slave  : FIFO side (sources + sink)
interface pipe_arbiter_if
  import pipe_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  src0_pop_front;
  logic [DATA_WIDTH-1:0] src0_data_out;
  logic                  src0_empty;
  logic                  src1_pop_front;
  logic [DATA_WIDTH-1:0] src1_data_out;
  logic                  src1_empty;
  logic                  sink_push_back;
  logic [DATA_WIDTH-1:0] sink_data_in;
  logic                  sink_full;

  modport master (
    output src0_pop_front, src1_pop_front, sink_push_back, sink_data_in,
    input  src0_data_out, src0_empty, src1_data_out, src1_empty, sink_full
  );

  modport slave (
    input  src0_pop_front, src1_pop_front, sink_push_back, sink_data_in,
    output src0_data_out, src0_empty, src1_data_out, src1_empty, sink_full
  );

endinterface

// File: rtl/pipe_arb_select.sv
// pipe_arb_select: combinational grant picker for the pipe arbiter.
//   src0_empty, src1_empty - source empty flags
//   prev_grant             - source served by the last transfer
//   req_valid_c            - at least one source has data
//   next_grant_c           - source to serve next
// Build option: PIPE_ARB_RR_EN defined -> round-robin when both sources hold
// data; undefined -> fixed priority with source 0 winning.
module pipe_arb_select (
  input  logic src0_empty,
  input  logic src1_empty,
  input  logic prev_grant,
  output logic req_valid_c,
  output logic next_grant_c
);

  always_comb begin
    req_valid_c  = !src0_empty || !src1_empty;
    next_grant_c = prev_grant;
`ifdef PIPE_ARB_RR_EN
    // Alternate only under contention; a lone requester always wins.
    if (!src0_empty && !src1_empty) begin
      next_grant_c = !prev_grant;
    end else if (!src0_empty) begin
      next_grant_c = 1'b0;
    end else if (!src1_empty) begin
      next_grant_c = 1'b1;
    end
`else
    if (!src0_empty) begin
      next_grant_c = 1'b0;
    end else if (!src1_empty) begin
      next_grant_c = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/pipe_arbiter.sv
// pipe_arbiter: moves single bytes from two pop-style sources into one
// push-style sink, one byte per IDLE->POP->CAPTURE->PUSH pass.
//   clk, rst       - clock, synchronous active-high reset
//   en             - permission to start new transfers
//   bus (master)   - source pop ports and sink push port
//   busy           - transfer in flight
//   grant          - source of the current or last transfer
//   xfer_count     - completed pushes, wraps
// Build option: PIPE_ARB_RR_EN selects round-robin arbitration (see
// pipe_arb_select); default is fixed priority to source 0.
module pipe_arbiter
  import pipe_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  pipe_arbiter_if.master       bus,
  output logic                 busy,
  output logic                 grant,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  arb_state_e            state_q;
  arb_state_e            state_d;
  logic                  grant_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  count_q;
  logic                  start_c;
  logic                  push_c;
  logic                  req_valid_c;
  logic                  next_grant_c;

  pipe_arb_select u_select (
    .src0_empty   (bus.src0_empty),
    .src1_empty   (bus.src1_empty),
    .prev_grant   (grant_q),
    .req_valid_c  (req_valid_c),
    .next_grant_c (next_grant_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; en only gates starts, so an in-flight transfer runs out.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    push_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && !bus.sink_full && req_valid_c) begin
          state_d = POP;
          start_c = 1'b1;
        end
      end
      POP:     state_d = CAPTURE;
      CAPTURE: state_d = PUSH;
      PUSH: begin
        // Backpressure holds the byte in data_q; a reset cycle never pushes.
        if (!bus.sink_full && !rst) begin
          push_c  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant latch, byte capture and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 1'b1;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      if (start_c) begin
        grant_q <= next_grant_c;
      end
      // Source head is valid the cycle after its pop, i.e. during CAPTURE.
      if (state_q == CAPTURE) begin
        data_q <= grant_q ? bus.src1_data_out : bus.src0_data_out;
      end
      if (push_c) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.src0_pop_front = (state_q == POP) && !grant_q;
  assign bus.src1_pop_front = (state_q == POP) && grant_q;
  assign bus.sink_push_back = push_c;
  assign bus.sink_data_in   = data_q;
  assign busy               = (state_q != IDLE);
  assign grant              = grant_q;
  assign xfer_count         = count_q;

endmodule

// File: tb/tb_pipe_arbiter.sv
// tb_pipe_arbiter: self-checking bench for pipe_arbiter. Behavioural FIFO
// sources feed the DUT; every pushed byte is compared against a queue of
// expected bytes. Counter width is reduced so the wrap case stays short.
module tb_pipe_arbiter;
  import pipe_arbiter_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          busy;
  logic          grant;
  logic [CW-1:0] xfer_count;

  pipe_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  pipe_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bus        (bus),
    .busy       (busy),
    .grant      (grant),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pops     = 0;
  int pushes   = 0;
  int pop_cyc  = -100;
  int push_cyc = -100;
  int start_cyc = -100;
  int push_gap = 0;
  logic busy_d   = 1'b0;
  logic pop_prev = 1'b0;

  logic [DW-1:0] src0_q[$];
  logic [DW-1:0] src1_q[$];
  logic [DW-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int s, input logic [DW-1:0] b);
    if (s == 0) src0_q.push_back(b);
    else        src1_q.push_back(b);
  endtask

  task automatic wait_count(input logic [CW-1:0] target, input int budget, input string name);
    int n = 0;
    while (xfer_count !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(xfer_count), 32'(target));
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd1);
  endtask

  // Source FIFOs: head byte appears the cycle after a pop.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.src0_pop_front && src0_q.size() > 0) bus.src0_data_out <= src0_q.pop_front();
    if (bus.src1_pop_front && src1_q.size() > 0) bus.src1_data_out <= src1_q.pop_front();
    bus.src0_empty <= (src0_q.size() == 0);
    bus.src1_empty <= (src1_q.size() == 0);
  end

  // Strobe monitor and sink scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (bus.sink_push_back) check("push_during_reset", 32'(bus.sink_push_back), 32'd0);
    end else begin
      if (busy && !busy_d) start_cyc = cyc;
      if (bus.src0_pop_front) begin
        pops++;
        pop_cyc = cyc;
        check("pop0_other_pop", 32'(bus.src1_pop_front), 32'd0);
        check("pop0_src_empty", 32'(bus.src0_empty), 32'd0);
        check("pop0_one_cycle", 32'(pop_prev), 32'd0);
      end
      if (bus.src1_pop_front) begin
        pops++;
        pop_cyc = cyc;
        check("pop1_other_pop", 32'(bus.src0_pop_front), 32'd0);
        check("pop1_src_empty", 32'(bus.src1_empty), 32'd0);
        check("pop1_one_cycle", 32'(pop_prev), 32'd0);
      end
      if (bus.sink_push_back) begin
        pushes++;
        push_gap = cyc - push_cyc;
        push_cyc = cyc;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push: got 0x%0h expected no push", bus.sink_data_in);
        end else begin
          check("push_data", 32'(bus.sink_data_in), 32'(sb.pop_front()));
        end
      end
    end
    busy_d   = busy;
    pop_prev = bus.src0_pop_front | bus.src1_pop_front;
  end

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          exp_grant;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [CW-1:0] exp_cnt;
    int p0;
    int n_wrap;

    vecs[0] = '{0, 8'h10, 1'b0};
    vecs[1] = '{1, 8'h20, 1'b1};
    vecs[2] = '{1, 8'h21, 1'b1};
    vecs[3] = '{0, 8'h11, 1'b0};
    vecs[4] = '{0, 8'h00, 1'b0};
    vecs[5] = '{1, 8'hFF, 1'b1};

    rst = 1'b1;
    en  = 1'b0;
    bus.sink_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd1);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_pop0", 32'(bus.src0_pop_front), 32'd0);
    check("rst_pop1", 32'(bus.src1_pop_front), 32'd0);
    check("rst_push", 32'(bus.sink_push_back), 32'd0);
    check("rst_data", 32'(bus.sink_data_in), 32'd0);
    rst = 1'b0;

    // Single byte from source 0: pop in the start cycle, push two cycles later
    load(0, 8'h41);
    sb.push_back(8'h41);
    en = 1'b1;
    wait_count(CW'(1), 20, "first_count");
    check("first_pop_latency", 32'(pop_cyc - start_cyc), 32'd0);
    check("first_push_latency", 32'(push_cyc - start_cyc), 32'd2);
    check("first_grant", 32'(grant), 32'd0);
    check("first_pushes", 32'(pushes), 32'd1);
    exp_cnt = CW'(1);

    // Single-source vectors: the lone requester is granted in either mode
    for (int i = 0; i < 6; i++) begin
      load(vecs[i].src, vecs[i].data);
      sb.push_back(vecs[i].data);
      exp_cnt = exp_cnt + CW'(1);
      wait_count(exp_cnt, 20, $sformatf("vec%0d_count", i));
      check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
    end

    // Contention: both sources loaded before starts are allowed
    en = 1'b0;
    load(0, 8'h30); load(0, 8'h31);
    load(1, 8'hA0); load(1, 8'hA1);
`ifdef PIPE_ARB_RR_EN
    sb.push_back(8'h30); sb.push_back(8'hA0); sb.push_back(8'h31); sb.push_back(8'hA1);
`else
    sb.push_back(8'h30); sb.push_back(8'h31); sb.push_back(8'hA0); sb.push_back(8'hA1);
`endif
    repeat (2) @(negedge clk);
    en = 1'b1;
    exp_cnt = exp_cnt + CW'(4);
    wait_count(exp_cnt, 40, "contend_count");
    check("contend_rate", 32'(push_gap), 32'd4);
    check("contend_sb_drained", 32'(sb.size()), 32'd0);

    // Sink backpressure while the byte sits in PUSH
    load(0, 8'h55);
    sb.push_back(8'h55);
    wait_busy("full_start");
    bus.sink_full = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("full_no_push", 32'(bus.sink_push_back), 32'd0);
      check("full_data_held", 32'(bus.sink_data_in), 32'h55);
      check("full_busy", 32'(busy), 32'd1);
    end
    check("full_count_held", 32'(xfer_count), 32'(exp_cnt));
    bus.sink_full = 1'b0;
    exp_cnt = exp_cnt + CW'(1);
    wait_count(exp_cnt, 10, "full_release_count");
    repeat (5) @(negedge clk);
    check("full_single_push", 32'(xfer_count), 32'(exp_cnt));
    check("full_sb_drained", 32'(sb.size()), 32'd0);

    // Reset while the transfer is in CAPTURE discards the byte
    load(1, 8'h77);
    wait_busy("rstcap_start");
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rstcap_busy", 32'(busy), 32'd0);
    check("rstcap_grant", 32'(grant), 32'd1);
    check("rstcap_count", 32'(xfer_count), 32'd0);
    check("rstcap_data", 32'(bus.sink_data_in), 32'd0);
    check("rstcap_pop", 32'(bus.src0_pop_front | bus.src1_pop_front), 32'd0);
    rst = 1'b0;
    load(0, 8'h5A);
    sb.push_back(8'h5A);
    wait_count(CW'(1), 20, "rstcap_next_count");
    check("rstcap_next_grant", 32'(grant), 32'd0);
    exp_cnt = CW'(1);

    // en low blocks starts; dropping en during POP lets that transfer finish
    en = 1'b0;
    p0 = pops;
    load(0, 8'h61);
    load(1, 8'h62);
    repeat (100) @(negedge clk);
    check("en_low_no_pop", 32'(pops - p0), 32'd0);
    check("en_low_idle", 32'(busy), 32'd0);
`ifdef PIPE_ARB_RR_EN
    sb.push_back(8'h62);
`else
    sb.push_back(8'h61);
`endif
    en = 1'b1;
    wait_busy("en_drop_start");
    en = 1'b0;
    repeat (30) @(negedge clk);
    exp_cnt = exp_cnt + CW'(1);
    check("en_drop_count", 32'(xfer_count), 32'(exp_cnt));
    check("en_drop_pops", 32'(pops - p0), 32'd1);
    check("en_drop_idle", 32'(busy), 32'd0);
`ifdef PIPE_ARB_RR_EN
    sb.push_back(8'h61);
`else
    sb.push_back(8'h62);
`endif
    en = 1'b1;
    exp_cnt = exp_cnt + CW'(1);
    wait_count(exp_cnt, 20, "en_drain_count");

    // Run the counter to all-ones, then one more push wraps it to zero
    n_wrap = (1 << CW) - 1 - int'(exp_cnt);
    for (int i = 0; i < n_wrap; i++) begin
      load(0, DW'(i));
      sb.push_back(DW'(i));
    end
    wait_count({CW{1'b1}}, n_wrap * 8 + 20, "wrap_max_count");
    load(0, 8'hEE);
    sb.push_back(8'hEE);
    wait_count(CW'(0), 20, "wrap_zero_count");
    repeat (3) @(negedge clk);
    check("wrap_sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
